// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: one-hot states, CSR addresses,
// interrupt cause codes and mstatus bit positions. Honours TRAP_MTVAL_EN.
package trap_ctrl_pkg;

    typedef enum logic [5:0] {
        S_IDLE     = 6'b000001,
        S_MEPC     = 6'b000010,
        S_MCAUSE   = 6'b000100,
`ifdef TRAP_MTVAL_EN
        S_MTVAL    = 6'b001000,
`endif
        S_MSTATUS  = 6'b010000,
        S_MRET     = 6'b100000
    } state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int unsigned IRQ_MSI    = 3;
    localparam int unsigned IRQ_MTI    = 7;
    localparam int unsigned IRQ_MEI    = 11;
    localparam int unsigned IRQ_LOCAL0 = 16;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_ctrl_irq_arb.sv
// Combinational interrupt priority encoder: MEI > MSI > MTI > local lines (lowest index first),
// gated by mstatus.MIE and the per-source mie enable bits.
module trap_irq_arb
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned CAUSE_W   = 5,
    parameter int unsigned NUM_LOCAL = 4
) (
    input  logic                 mstatus_mie,
    input  logic                 irq_msi,
    input  logic                 irq_mti,
    input  logic                 irq_mei,
    input  logic [NUM_LOCAL-1:0] irq_local,
    input  logic [XLEN-1:0]      mie,
    output logic                 irq_valid,
    output logic [CAUSE_W-1:0]   irq_code
);

    logic unused_mie;
    assign unused_mie = ^mie;

    always_comb begin
        irq_valid = 1'b0;
        irq_code  = '0;
        if (mstatus_mie) begin
            if (irq_mei && mie[IRQ_MEI]) begin
                irq_valid = 1'b1;
                irq_code  = CAUSE_W'(IRQ_MEI);
            end else if (irq_msi && mie[IRQ_MSI]) begin
                irq_valid = 1'b1;
                irq_code  = CAUSE_W'(IRQ_MSI);
            end else if (irq_mti && mie[IRQ_MTI]) begin
                irq_valid = 1'b1;
                irq_code  = CAUSE_W'(IRQ_MTI);
            end else begin
                for (int unsigned i = 0; i < NUM_LOCAL; i++) begin
                    if (!irq_valid && irq_local[i] && mie[IRQ_LOCAL0 + i]) begin
                        irq_valid = 1'b1;
                        irq_code  = CAUSE_W'(IRQ_LOCAL0 + i);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions, MRET and interrupts, redirects fetch and
// sequences mepc/mcause/[mtval]/mstatus over one CSR write port. MTVAL write under TRAP_MTVAL_EN.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned CAUSE_W   = 5,
    parameter int unsigned NUM_LOCAL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 exc_valid_i,
    input  logic [CAUSE_W-1:0]   exc_cause_i,
    input  logic [XLEN-1:0]      exc_pc_i,
    input  logic [XLEN-1:0]      exc_tval_i,
    input  logic                 mret_i,
    input  logic [XLEN-1:0]      int_pc_i,
    input  logic                 irq_msi_i,
    input  logic                 irq_mti_i,
    input  logic                 irq_mei_i,
    input  logic [NUM_LOCAL-1:0] irq_local_i,
    output logic                 redirect_valid_o,
    output logic [XLEN-1:0]      redirect_addr_o,
    output logic                 busy_o,
    output logic                 csr_we_o,
    output logic [11:0]          csr_addr_o,
    output logic [XLEN-1:0]      csr_data_o,
    input  logic [XLEN-1:0]      csr_mstatus_i,
    input  logic [XLEN-1:0]      csr_mie_i,
    input  logic [XLEN-1:0]      csr_mtvec_i,
    input  logic [XLEN-1:0]      csr_mepc_i
);

    state_e             state;
    logic [XLEN-1:0]    mcause_q;
    logic [XLEN-1:0]    mstatus_q;
`ifdef TRAP_MTVAL_EN
    logic [XLEN-1:0]    tval_q;
`else
    logic               unused_tval;
    assign unused_tval = ^exc_tval_i;
`endif

    logic               irq_valid;
    logic [CAUSE_W-1:0] irq_code;
    logic               idle_ok;
    logic               take_exc;
    logic               take_mret;
    logic               take_irq;
    logic               take_trap;
    logic [CAUSE_W-1:0] trap_code;
    logic [XLEN-1:0]    trap_base;
    logic [XLEN-1:0]    trap_target;
    logic [XLEN-1:0]    mcause_val;

    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    trap_irq_arb #(
        .XLEN      (XLEN),
        .CAUSE_W   (CAUSE_W),
        .NUM_LOCAL (NUM_LOCAL)
    ) u_irq_arb (
        .mstatus_mie (csr_mstatus_i[MSTATUS_MIE]),
        .irq_msi     (irq_msi_i),
        .irq_mti     (irq_mti_i),
        .irq_mei     (irq_mei_i),
        .irq_local   (irq_local_i),
        .mie         (csr_mie_i),
        .irq_valid   (irq_valid),
        .irq_code    (irq_code)
    );

    always_comb begin
        idle_ok     = rst_n && (state == S_IDLE) && !stall_i;
        take_exc    = idle_ok && exc_valid_i;
        take_mret   = idle_ok && !exc_valid_i && mret_i;
        take_irq    = idle_ok && !exc_valid_i && !mret_i && irq_valid;
        take_trap   = take_exc || take_irq;
        trap_code   = take_exc ? exc_cause_i : irq_code;
        trap_base   = {csr_mtvec_i[XLEN-1:2], 2'b00};
        // Only interrupts are vectored; modes 2/3 fall back to the base address.
        trap_target = (take_irq && csr_mtvec_i[1:0] == 2'b01)
                    ? trap_base + (XLEN'(trap_code) << 2) : trap_base;
        mcause_val  = '0;
        mcause_val[CAUSE_W-1:0] = trap_code;
        mcause_val[XLEN-1]      = take_irq;
        redirect_valid_o = take_trap || take_mret;
        redirect_addr_o  = take_mret ? csr_mepc_i : (take_trap ? trap_target : '0);
    end

    assign busy_o = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            csr_we_o   <= 1'b0;
            csr_addr_o <= '0;
            csr_data_o <= '0;
            mcause_q   <= '0;
            mstatus_q  <= '0;
`ifdef TRAP_MTVAL_EN
            tval_q     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    csr_we_o   <= 1'b0;
                    csr_addr_o <= '0;
                    csr_data_o <= '0;
                    if (take_trap) begin
                        state      <= S_MEPC;
                        csr_we_o   <= 1'b1;
                        csr_addr_o <= CSR_MEPC;
                        csr_data_o <= take_exc ? exc_pc_i : int_pc_i;
                        mcause_q   <= mcause_val;
                        mstatus_q  <= csr_mstatus_i;
`ifdef TRAP_MTVAL_EN
                        tval_q     <= take_exc ? exc_tval_i : '0;
`endif
                    end else if (take_mret) begin
                        state      <= S_MRET;
                        csr_we_o   <= 1'b1;
                        csr_addr_o <= CSR_MSTATUS;
                        csr_data_o <= mret_mstatus(csr_mstatus_i);
                        mstatus_q  <= csr_mstatus_i;
                    end
                end
                S_MEPC: begin
                    state      <= S_MCAUSE;
                    csr_we_o   <= 1'b1;
                    csr_addr_o <= CSR_MCAUSE;
                    csr_data_o <= mcause_q;
                end
                S_MCAUSE: begin
                    csr_we_o   <= 1'b1;
`ifdef TRAP_MTVAL_EN
                    state      <= S_MTVAL;
                    csr_addr_o <= CSR_MTVAL;
                    csr_data_o <= tval_q;
`else
                    state      <= S_MSTATUS;
                    csr_addr_o <= CSR_MSTATUS;
                    csr_data_o <= trap_mstatus(mstatus_q);
`endif
                end
`ifdef TRAP_MTVAL_EN
                S_MTVAL: begin
                    state      <= S_MSTATUS;
                    csr_we_o   <= 1'b1;
                    csr_addr_o <= CSR_MSTATUS;
                    csr_data_o <= trap_mstatus(mstatus_q);
                end
`endif
                S_MSTATUS, S_MRET: begin
                    state      <= S_IDLE;
                    csr_we_o   <= 1'b0;
                    csr_addr_o <= '0;
                    csr_data_o <= '0;
                end
                default: begin
                    state      <= S_IDLE;
                    csr_we_o   <= 1'b0;
                    csr_addr_o <= '0;
                    csr_data_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a behavioural model predicts redirects and CSR writes,
// a negedge monitor compares them and plays the role of csr_reg.
module tb_trap_ctrl;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned CAUSE_W   = 5;
    localparam int unsigned NUM_LOCAL = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 stall_i;
    logic                 exc_valid_i;
    logic [CAUSE_W-1:0]   exc_cause_i;
    logic [XLEN-1:0]      exc_pc_i;
    logic [XLEN-1:0]      exc_tval_i;
    logic                 mret_i;
    logic [XLEN-1:0]      int_pc_i;
    logic                 irq_msi_i;
    logic                 irq_mti_i;
    logic                 irq_mei_i;
    logic [NUM_LOCAL-1:0] irq_local_i;
    logic                 redirect_valid_o;
    logic [XLEN-1:0]      redirect_addr_o;
    logic                 busy_o;
    logic                 csr_we_o;
    logic [11:0]          csr_addr_o;
    logic [XLEN-1:0]      csr_data_o;
    logic [XLEN-1:0]      csr_mstatus;
    logic [XLEN-1:0]      csr_mie;
    logic [XLEN-1:0]      csr_mtvec;
    logic [XLEN-1:0]      csr_mepc;

    typedef struct packed {
        logic [11:0] a;
        logic [63:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [63:0] exp_rd[$];
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    trap_ctrl #(
        .XLEN      (XLEN),
        .CAUSE_W   (CAUSE_W),
        .NUM_LOCAL (NUM_LOCAL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .exc_valid_i      (exc_valid_i),
        .exc_cause_i      (exc_cause_i),
        .exc_pc_i         (exc_pc_i),
        .exc_tval_i       (exc_tval_i),
        .mret_i           (mret_i),
        .int_pc_i         (int_pc_i),
        .irq_msi_i        (irq_msi_i),
        .irq_mti_i        (irq_mti_i),
        .irq_mei_i        (irq_mei_i),
        .irq_local_i      (irq_local_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_addr_o  (redirect_addr_o),
        .busy_o           (busy_o),
        .csr_we_o         (csr_we_o),
        .csr_addr_o       (csr_addr_o),
        .csr_data_o       (csr_data_o),
        .csr_mstatus_i    (csr_mstatus),
        .csr_mie_i        (csr_mie),
        .csr_mtvec_i      (csr_mtvec),
        .csr_mepc_i       (csr_mepc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    // Monitor: pops the scoreboard on every redirect/write and updates the CSR file it models.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (mon_en) begin
            if (redirect_valid_o) begin
                if (exp_rd.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL redirect_unexpected actual=%h required=none", redirect_addr_o);
                end else begin
                    check("redirect_addr", redirect_addr_o, exp_rd.pop_front());
                end
            end else begin
                check("redirect_addr_idle", redirect_addr_o, 64'h0);
            end
            if (csr_we_o) begin
                check("busy_during_write", {63'h0, busy_o}, 64'h1);
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL write_unexpected actual=%h:%h required=none", csr_addr_o, csr_data_o);
                end else begin
                    e = exp_wr.pop_front();
                    check("csr_addr", {52'h0, csr_addr_o}, {52'h0, e.a});
                    check("csr_data", csr_data_o, e.d);
                    if (e.a == 12'h341) csr_mepc = e.d;
                    if (e.a == 12'h300) csr_mstatus = e.d;
                end
            end
        end
    end

    // Reference model: decides what the request set should produce and queues the expectations.
    task automatic push_expect(input bit ev, input logic [4:0] cause, input logic [63:0] pc,
                               input logic [63:0] tval, input bit mr, input bit msi, input bit mti,
                               input bit mei, input logic [3:0] loc, input logic [63:0] ipc,
                               input int max_wr, output bit taken);
        int unsigned prio[7] = '{11, 3, 7, 16, 17, 18, 19};
        logic [31:0] pend;
        logic [31:0] elig;
        int unsigned code = 0;
        bit          intr = 1'b0;
        bit          trap = 1'b0;
        logic [63:0] base;
        logic [63:0] tgt;
        logic [63:0] mc;
        logic [63:0] ms;
        wr_t         wl[$];
        ms = csr_mstatus;
        taken = 1'b1;
        if (ev) begin
            trap = 1'b1;
            code = cause;
        end else if (!mr) begin
            pend = '0;
            pend[3] = msi;
            pend[7] = mti;
            pend[11] = mei;
            pend[19:16] = loc;
            elig = ms[3] ? (pend & csr_mie[31:0]) : 32'h0;
            for (int k = 0; k < 7; k++) begin
                if (!trap && elig[prio[k]]) begin
                    trap = 1'b1;
                    intr = 1'b1;
                    code = prio[k];
                end
            end
            if (!trap) taken = 1'b0;
        end
        if (trap) begin
            base = csr_mtvec & ~64'h3;
            tgt = (intr && csr_mtvec[1:0] == 2'b01) ? base + (64'(code) << 2) : base;
            exp_rd.push_back(tgt);
            mc = 64'(code);
            mc[63] = intr;
            wl.push_back('{a: 12'h341, d: (intr ? ipc : pc)});
            wl.push_back('{a: 12'h342, d: mc});
`ifdef TRAP_MTVAL_EN
            wl.push_back('{a: 12'h343, d: (intr ? 64'h0 : tval)});
`endif
            wl.push_back('{a: 12'h300, d: (ms & ~64'h1888) | (ms[3] ? 64'h80 : 64'h0) | 64'h1800});
        end else if (taken) begin
            exp_rd.push_back(csr_mepc);
            wl.push_back('{a: 12'h300, d: (ms & ~64'h1888) | (ms[7] ? 64'h8 : 64'h0) | 64'h1880});
        end
        for (int i = 0; i < wl.size() && i < max_wr; i++) exp_wr.push_back(wl[i]);
        if (ev == 1'b0 && tval == 64'h1) $display("note: tval ignored for interrupts");
    endtask

    task automatic clear_req();
        exc_valid_i = 1'b0;
        mret_i      = 1'b0;
        irq_msi_i   = 1'b0;
        irq_mti_i   = 1'b0;
        irq_mei_i   = 1'b0;
        irq_local_i = '0;
        stall_i     = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy_o) begin
            total++;
            bad++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic setup_csr(input logic [63:0] ms, input logic [63:0] ie,
                             input logic [63:0] tv, input logic [63:0] ep);
        wait_idle();
        csr_mstatus = ms;
        csr_mie     = ie;
        csr_mtvec   = tv;
        csr_mepc    = ep;
    endtask

    task automatic run_txn(input bit ev, input logic [4:0] cause, input logic [63:0] pc,
                           input logic [63:0] tval, input bit mr, input bit msi, input bit mti,
                           input bit mei, input logic [3:0] loc, input int stall_n, input int max_wr);
        bit taken;
        wait_idle();
        exc_valid_i = ev;
        exc_cause_i = cause;
        exc_pc_i    = pc;
        exc_tval_i  = tval;
        mret_i      = mr;
        irq_msi_i   = msi;
        irq_mti_i   = mti;
        irq_mei_i   = mei;
        irq_local_i = loc;
        int_pc_i    = r64();
        stall_i     = (stall_n > 0);
        for (int i = 0; i < stall_n; i++) begin
            @(posedge clk);
            #1;
            check("busy_while_stalled", {63'h0, busy_o}, 64'h0);
        end
        stall_i = 1'b0;
        push_expect(ev, cause, pc, tval, mr, msi, mti, mei, loc, int_pc_i, max_wr, taken);
        if (taken) begin
            @(posedge clk);
            #1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                @(posedge clk);
                #1;
                check("busy_not_taken", {63'h0, busy_o}, 64'h0);
            end
        end
        clear_req();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_req();
        exc_cause_i = '0;
        exc_pc_i    = '0;
        exc_tval_i  = '0;
        int_pc_i    = '0;
        csr_mstatus = '0;
        csr_mie     = '0;
        csr_mtvec   = '0;
        csr_mepc    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_redirect_valid", {63'h0, redirect_valid_o}, 64'h0);
        check("rst_redirect_addr", redirect_addr_o, 64'h0);
        check("rst_busy", {63'h0, busy_o}, 64'h0);
        check("rst_csr_we", {63'h0, csr_we_o}, 64'h0);
        check("rst_csr_addr", {52'h0, csr_addr_o}, 64'h0);
        check("rst_csr_data", csr_data_o, 64'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Exception, direct mode.
        setup_csr(64'h8, 64'h0, 64'h8000_0100, 64'h0);
        run_txn(1'b1, 5'd2, 64'h8000_0010, 64'h0000_0000_dead_beef, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 99);
        // Vectored MTI.
        setup_csr(64'h8, 64'h80, 64'h8000_0101, 64'h0);
        run_txn(1'b0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 0, 99);
        // Exception beats pending interrupts, then MEI wins once MIE is back.
        setup_csr(64'h8, 64'h10880, 64'h8000_0101, 64'h0);
        run_txn(1'b1, 5'd4, 64'h8000_0040, 64'h44, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 0, 99);
        setup_csr(64'h8, 64'h10880, 64'h8000_0101, 64'h0);
        run_txn(1'b0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 0, 99);
        // MRET.
        setup_csr(64'h1880, 64'h0, 64'h8000_0100, 64'h8000_0200);
        run_txn(1'b0, 5'd0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 0, 99);
        // Masked by mstatus.MIE=0.
        setup_csr(64'h0, 64'h800, 64'h8000_0100, 64'h0);
        run_txn(1'b0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 0, 99);
        // Masked by stall: request dropped before stall is released.
        setup_csr(64'h8, 64'h800, 64'h8000_0100, 64'h0);
        stall_i   = 1'b1;
        irq_mei_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall_busy", {63'h0, busy_o}, 64'h0);
            check("stall_we", {63'h0, csr_we_o}, 64'h0);
        end
        clear_req();

        // Reset in the MCAUSE state: only mepc and mcause may appear.
        setup_csr(64'h8, 64'h0, 64'h8000_0100, 64'h0);
        run_txn(1'b1, 5'd3, 64'h8000_0080, 64'h88, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_we", {63'h0, csr_we_o}, 64'h0);
        check("midrst_busy", {63'h0, busy_o}, 64'h0);
        check("midrst_addr", {52'h0, csr_addr_o}, 64'h0);
        check("midrst_data", csr_data_o, 64'h0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_pending_writes", 64'(exp_wr.size()), 64'h0);

        // Randomised transactions.
        for (int n = 0; n < 60; n++) begin
            setup_csr(r64() | (($urandom_range(0, 3) != 0) ? 64'h8 : 64'h0),
                      r64() & 64'hF0888, r64(), r64());
            run_txn($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), r64(), r64(),
                    $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)), 99);
        end

        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check("leftover_redirects", 64'(exp_rd.size()), 64'h0);
        check("leftover_writes", 64'(exp_wr.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
